// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, parity selectors and word width.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Parity bit that makes the total count of ones even (PAR_EVEN) or odd (PAR_ODD).
  function automatic logic parity_bit(input logic [UART_DATA_W-1:0] d, input logic typ);
    return (typ == PAR_EVEN) ? ^d : ~^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side and serial output of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] p_data;
  logic                   data_valid;
  logic                   par_en;
  logic                   par_typ;
  logic                   tx_out;
  logic                   busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy
  );

endinterface

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period counter: pulses bit_done on the last cycle of every CLKS_PER_BIT period.
module uart_tx_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned    CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // End-of-period detect and next count; clear holds the counter at zero while idle.
  always_comb begin
    bit_done = !clear && (cnt_q == CNT_LAST);
    cnt_d    = (clear || bit_done) ? '0 : cnt_q + CNT_W'(1);
  end

  // Cycle counter register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  uart_tx_if.slave bus
);

  uart_tx_state_t         state_q;
  logic [UART_DATA_W-1:0] data_q;
  logic [2:0]             idx_q;
  logic [2:0]             idx_d;
  logic                   par_en_q;
  logic                   par_bit_q;
  logic                   tx_q;
  logic                   busy_q;
  logic                   bit_done;
  logic                   cnt_clear;

  uart_tx_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .bit_done(bit_done)
  );

  // The counter restarts on the acceptance edge, so each bit lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    cnt_clear = (state_q == IDLE);
    idx_d     = idx_q + 3'd1;
  end

  // Frame FSM with registered line and busy outputs; fields latched only at acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.data_valid) begin
            state_q   <= START;
            data_q    <= bus.p_data;
            par_en_q  <= bus.par_en;
            par_bit_q <= parity_bit(bus.p_data, bus.par_typ);
            idx_q     <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= data_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (idx_q == 3'd7) begin
              idx_q <= '0;
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_d;
              tx_q  <= data_q[idx_d];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int unsigned CPB = 4;

  logic clk;
  logic rst;

  uart_tx_if bus4 ();
  uart_tx_if bus1 ();

  uart_tx #(.CLKS_PER_BIT(CPB)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  uart_tx #(.CLKS_PER_BIT(1))   dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        pen;
    logic        ptyp;
    logic        exp_par;
    int unsigned exp_busy;
    logic        poke;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full frame on dut4, checked every cycle; inputs scrambled after acceptance.
  task automatic run_frame(input vec_t v, input int vi);
    int unsigned nbits;
    int unsigned busy_n;
    logic        exp;
    nbits  = v.pen ? 11 : 10;
    busy_n = 0;
    @(negedge clk);
    bus4.p_data = v.data; bus4.par_en = v.pen; bus4.par_typ = v.ptyp; bus4.data_valid = 1'b1;
    @(negedge clk);
    bus4.data_valid = 1'b0;
    bus4.p_data = ~v.data; bus4.par_en = ~v.pen; bus4.par_typ = ~v.ptyp;
    for (int k = 0; k < int'(nbits); k++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        if (k == 0)                exp = 1'b0;
        else if (k <= 8)           exp = v.data[k-1];
        else if (k == 9 && v.pen)  exp = v.exp_par;
        else                       exp = 1'b1;
        chk($sformatf("vec%0d bit%0d cyc%0d tx", vi, k, c), bus4.tx_out, exp);
        if (bus4.busy) busy_n++;
        if (v.poke && k == 3 && c == 1) begin
          bus4.data_valid = 1'b1; bus4.p_data = 8'h3C; bus4.par_en = 1'b0;
        end else begin
          bus4.data_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk($sformatf("vec%0d end busy", vi), bus4.busy, 1'b0);
    chk($sformatf("vec%0d end tx", vi), bus4.tx_out, 1'b1);
    chk_int($sformatf("vec%0d busy cycles", vi), busy_n, v.exp_busy);
    for (int i = 0; i < int'(2 * CPB); i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d idle tx", vi), bus4.tx_out, 1'b1);
      chk($sformatf("vec%0d idle busy", vi), bus4.busy, 1'b0);
    end
  endtask

  initial begin
    logic [10:0] pat1;
    logic        exp_tx;
    logic        exp_busy;
    int unsigned run;
    vec_t        v;

    // data, par_en, par_typ, expected parity bit, expected busy cycles, mid-frame poke
    vecs[0] = '{8'hA5, 1'b1, PAR_EVEN, 1'b0, 44, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, PAR_ODD,  1'b1, 44, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, PAR_EVEN, 1'b0, 40, 1'b0};
    vecs[3] = '{8'h00, 1'b1, PAR_ODD,  1'b1, 44, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, PAR_EVEN, 1'b0, 44, 1'b1};
    vecs[5] = '{8'h01, 1'b1, PAR_EVEN, 1'b1, 44, 1'b1};

    bus4.p_data = 8'hA5; bus4.par_en = 1'b0; bus4.par_typ = 1'b0; bus4.data_valid = 1'b1;
    bus1.p_data = 8'hA5; bus1.par_en = 1'b0; bus1.par_typ = 1'b0; bus1.data_valid = 1'b1;
    rst = 1'b0;

    // Reset held with a pending request.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset tx", bus4.tx_out, 1'b1);
      chk("reset busy", bus4.busy, 1'b0);
      chk("reset tx cpb1", bus1.tx_out, 1'b1);
    end
    rst = 1'b1;
    bus4.data_valid = 1'b0;
    bus1.data_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post-reset tx", bus4.tx_out, 1'b1);
      chk("post-reset busy", bus4.busy, 1'b0);
    end

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Back-to-back: 0x00 then 0xFF with data_valid held, no parity.
    @(negedge clk);
    bus4.p_data = 8'h00; bus4.par_en = 1'b0; bus4.par_typ = 1'b0; bus4.data_valid = 1'b1;
    run = 0;
    for (int n = 0; n <= 81; n++) begin
      @(negedge clk);
      exp_tx   = (n < 36) ? 1'b0 : (n < 41) ? 1'b1 : (n < 45) ? 1'b0 : 1'b1;
      exp_busy = (n < 40) || (n >= 41 && n < 81);
      chk($sformatf("b2b n%0d tx", n), bus4.tx_out, exp_tx);
      chk($sformatf("b2b n%0d busy", n), bus4.busy, exp_busy);
      if (n >= 30 && n <= 44 && bus4.tx_out === 1'b1) run++;
      if (n == 0) bus4.p_data = 8'hFF;
      if (n == 41) bus4.data_valid = 1'b0;
    end
    chk_int("b2b stop level cycles", run, CPB + 1);

    // Reset during data bit 3, then a clean frame.
    @(negedge clk);
    bus4.p_data = 8'hA5; bus4.par_en = 1'b0; bus4.data_valid = 1'b1;
    @(negedge clk);
    bus4.data_valid = 1'b0;
    for (int n = 1; n <= 17; n++) @(negedge clk);
    chk("midreset pre tx", bus4.tx_out, 1'b0);
    chk("midreset pre busy", bus4.busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset tx", bus4.tx_out, 1'b1);
    chk("midreset busy", bus4.busy, 1'b0);
    rst = 1'b1;
    v = '{8'h96, 1'b1, PAR_ODD, 1'b1, 44, 1'b0};
    run_frame(v, 6);

    // CLKS_PER_BIT=1: 0xA5 even parity, request held so the next frame starts after 2 stop-level cycles.
    pat1 = 11'b10101001010;
    @(negedge clk);
    bus1.p_data = 8'hA5; bus1.par_en = 1'b1; bus1.par_typ = PAR_EVEN; bus1.data_valid = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      exp_tx   = (n <= 10) ? pat1[n] : (n == 11) ? 1'b1 : 1'b0;
      exp_busy = (n != 11);
      chk($sformatf("cpb1 n%0d tx", n), bus1.tx_out, exp_tx);
      chk($sformatf("cpb1 n%0d busy", n), bus1.busy, exp_busy);
    end
    bus1.data_valid = 1'b0;
    for (int n = 0; n < 15; n++) @(negedge clk);
    chk("cpb1 final busy", bus1.busy, 1'b0);
    chk("cpb1 final tx", bus1.tx_out, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
